// File: rtl/mul_scheduler_pkg.sv
// Shared types and default parameters for the multiplier scheduler.
package mul_scheduler_pkg;

    localparam int unsigned N_REQ_DEF   = 4;
    localparam int unsigned WIDTH_DEF   = 8;
    localparam int unsigned TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StWait,
        StResp
    } state_e;

endpackage

// File: rtl/mul_scheduler_if.sv
// Requester and multiplier-side signals of the scheduler, bundled as one interface.
interface mul_scheduler_if import mul_scheduler_pkg::*; #(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned WIDTH = WIDTH_DEF
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] a_in;
    logic [N_REQ*WIDTH-1:0] b_in;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       rsp_valid;
    logic [2*WIDTH-1:0]     rsp_data;
    logic                   rsp_err;
    logic                   mul_start;
    logic [WIDTH-1:0]       mul_a;
    logic [WIDTH-1:0]       mul_b;
    logic                   mul_done;
    logic [2*WIDTH-1:0]     mul_p;

    // Requesters plus the multiplier, as seen from outside the scheduler.
    modport master (
        output req, a_in, b_in, mul_done, mul_p,
        input  gnt, rsp_valid, rsp_data, rsp_err, mul_start, mul_a, mul_b
    );

    // The scheduler itself.
    modport slave (
        input  req, a_in, b_in, mul_done, mul_p,
        output gnt, rsp_valid, rsp_data, rsp_err, mul_start, mul_a, mul_b
    );
endinterface

// File: rtl/mul_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester after last_gnt, wrapping around.
module rr_arbiter import mul_scheduler_pkg::*; #(
    parameter int unsigned N_REQ = N_REQ_DEF,
    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_gnt,
    output logic [N_REQ-1:0] grant
);

    logic [IDX_W-1:0] idx;
    logic             found;

    // Scan offsets 1..N_REQ from last_gnt; the first set request wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = IDX_W'((32'(last_gnt) + k) % N_REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_scheduler.sv
// Shares one multiplier between N_REQ requesters: grant, launch, wait (with watchdog), respond.
module mul_scheduler import mul_scheduler_pkg::*; #(
    parameter int unsigned N_REQ   = N_REQ_DEF,
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input logic          clk,
    input logic          rst,
    mul_scheduler_if.slave bus
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   last_gnt_q, last_gnt_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [WIDTH-1:0]   mul_a_q, mul_a_d;
    logic [WIDTH-1:0]   mul_b_q, mul_b_d;
    logic [2*WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic               rsp_err_q, rsp_err_d;
    logic [WD_W-1:0]    wd_q, wd_d;

    logic [N_REQ-1:0]   arb_gnt;
    logic [IDX_W-1:0]   arb_idx;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req      (bus.req),
        .last_gnt (last_gnt_q),
        .grant    (arb_gnt)
    );

    // Encode the one-hot winner into an index for operand selection and ownership.
    always_comb begin
        arb_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (arb_gnt[i]) begin
                arb_idx = IDX_W'(i);
            end
        end
    end

    // Next-state and pulse outputs of the four-state operation sequencer.
    always_comb begin
        state_d       = state_q;
        last_gnt_d    = last_gnt_q;
        owner_d       = owner_q;
        mul_a_d       = mul_a_q;
        mul_b_d       = mul_b_q;
        rsp_data_d    = rsp_data_q;
        rsp_err_d     = rsp_err_q;
        wd_d          = wd_q;
        bus.gnt       = '0;
        bus.mul_start = 1'b0;
        bus.rsp_valid = '0;

        unique case (state_q)
            StIdle: begin
                if (|bus.req) begin
                    bus.gnt    = arb_gnt;
                    last_gnt_d = arb_idx;
                    owner_d    = arb_idx;
                    mul_a_d    = bus.a_in[arb_idx*WIDTH +: WIDTH];
                    mul_b_d    = bus.b_in[arb_idx*WIDTH +: WIDTH];
                    state_d    = StLaunch;
                end
            end
            StLaunch: begin
                // mul_done is deliberately not looked at here.
                bus.mul_start = 1'b1;
                wd_d          = '0;
                state_d       = StWait;
            end
            StWait: begin
                wd_d = wd_q + 1'b1;
                // Completion takes priority over an expiry in the same cycle.
                if (bus.mul_done) begin
                    rsp_data_d = bus.mul_p;
                    rsp_err_d  = 1'b0;
                    state_d    = StResp;
                end else if (wd_q == WD_W'(TIMEOUT - 2)) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = StResp;
                end
            end
            StResp: begin
                bus.rsp_valid[owner_q] = 1'b1;
                state_d                = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // No pulses while reset is held, so a held reset cannot grant without launching.
        if (rst) begin
            bus.gnt       = '0;
            bus.mul_start = 1'b0;
            bus.rsp_valid = '0;
        end
    end

    // State register with synchronous reset; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            last_gnt_q <= IDX_W'(N_REQ - 1);
            owner_q    <= '0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            wd_q       <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            owner_q    <= owner_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            wd_q       <= wd_d;
        end
    end

    assign bus.mul_a    = mul_a_q;
    assign bus.mul_b    = mul_b_q;
    assign bus.rsp_data = rsp_data_q;
    assign bus.rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_mul_scheduler.sv
// Randomized bench for mul_scheduler with a multiplier stand-in and a round-robin reference model.
module tb_mul_scheduler;
    import mul_scheduler_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 8;
    localparam int unsigned TO = 64;

    logic clk = 1'b0;
    logic rst;

    mul_scheduler_if #(.N_REQ(N), .WIDTH(W)) bus ();

    mul_scheduler #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int model_last = N - 1;

    logic [W-1:0] op_a [N];
    logic [W-1:0] op_b [N];
    logic [N-1:0] pending = '0;
    bit           sticky = 1'b0;
    int           fixed_lat = 1;     // >0 fixed latency, 0 random 1..8, <0 never completes
    bit           inject_launch = 1'b0;
    int           overlap_cnt = 0;

    int               g_cyc[$];
    logic [N-1:0]     g_vec[$];
    logic [N-1:0]     g_req[$];
    int               s_cyc[$];
    logic [W-1:0]     s_a[$];
    logic [W-1:0]     s_b[$];
    int               r_cyc[$];
    logic [N-1:0]     r_vec[$];
    logic [2*W-1:0]   r_data[$];
    logic             r_err[$];
    int               lat_q[$];

    // Reference: signed product, sign-extended to 2*W bits then truncated.
    function automatic logic [2*W-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] sa, sb;
        sa = {{W{a[W-1]}}, a};
        sb = {{W{b[W-1]}}, b};
        return sa * sb;
    endfunction

    // Reference: next requester after 'last' with its request bit set.
    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= int'(N); k++) begin
            if (r[(last + k) % int'(N)]) return (last + k) % int'(N);
        end
        return -1;
    endfunction

    // Reference: cycles from launch to response for a given multiplier latency.
    function automatic int exp_delay(input int lat);
        return (lat >= 1 && lat <= int'(TO) - 1) ? lat + 1 : int'(TO);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Requester driver: present pending requests and operand slices.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            bus.req = pending;
            for (int i = 0; i < int'(N); i++) begin
                bus.a_in[i*W +: W] = op_a[i];
                bus.b_in[i*W +: W] = op_b[i];
            end
        end
    end

    // Multiplier stand-in: completes 'lat' cycles after the launch cycle.
    initial begin
        int cnt;
        int lat;
        logic [W-1:0] ca, cb;
        cnt = -1;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                cnt = -1;
                bus.mul_done = 1'b0;
            end else if (bus.mul_start) begin
                ca = bus.mul_a;
                cb = bus.mul_b;
                lat = (fixed_lat == 0) ? int'($urandom_range(1, 8)) : fixed_lat;
                lat_q.push_back(lat);
                cnt = lat;
                bus.mul_done = inject_launch;
                bus.mul_p = (2*W)'($urandom);
            end else if (cnt > 0) begin
                cnt--;
                bus.mul_done = (cnt == 0);
                bus.mul_p = (cnt == 0) ? prod(ca, cb) : (2*W)'($urandom);
            end else begin
                bus.mul_done = 1'b0;
            end
        end
    end

    // Event logger; also drops a request once its grant is seen.
    always @(negedge clk) begin
        if (|bus.gnt) begin
            g_cyc.push_back(cyc); g_vec.push_back(bus.gnt); g_req.push_back(bus.req);
        end
        if (bus.mul_start) begin
            s_cyc.push_back(cyc); s_a.push_back(bus.mul_a); s_b.push_back(bus.mul_b);
        end
        if (|bus.rsp_valid) begin
            r_cyc.push_back(cyc); r_vec.push_back(bus.rsp_valid);
            r_data.push_back(bus.rsp_data); r_err.push_back(bus.rsp_err);
        end
        if ($countones({|bus.gnt, bus.mul_start, |bus.rsp_valid}) > 1 ||
            $countones(bus.gnt) > 1 || $countones(bus.rsp_valid) > 1) overlap_cnt++;
        if (!sticky) pending = pending & ~bus.gnt;
    end

    task automatic clear_logs();
        g_cyc.delete(); g_vec.delete(); g_req.delete();
        s_cyc.delete(); s_a.delete(); s_b.delete();
        r_cyc.delete(); r_vec.delete(); r_data.delete(); r_err.delete();
        lat_q.delete();
    endtask

    task automatic wait_rsps(input int n, input int budget, output bit ok);
        int t = 0;
        while (r_cyc.size() < n && t < budget) begin
            @(negedge clk);
            #1;
            t++;
        end
        ok = (r_cyc.size() >= n);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #3 rst = 1'b1;
        @(posedge clk); #3 rst = 1'b0;
        model_last = N - 1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.gnt !== '0) begin errors++; $display("FAIL reset_gnt: got %b want 0", bus.gnt); end
        checks++; if (bus.rsp_valid !== '0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        checks++; if (bus.mul_start !== 1'b0) begin errors++; $display("FAIL reset_mul_start: got %b want 0", bus.mul_start); end
        checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b want 0", bus.rsp_err); end
        checks++; if (bus.rsp_data !== '0) begin errors++; $display("FAIL reset_rsp_data: got %h want 0", bus.rsp_data); end
        checks++; if (bus.mul_a !== '0) begin errors++; $display("FAIL reset_mul_a: got %h want 0", bus.mul_a); end
        checks++; if (bus.mul_b !== '0) begin errors++; $display("FAIL reset_mul_b: got %h want 0", bus.mul_b); end
        @(posedge clk); #3 rst = 1'b0;
        model_last = N - 1;
    endtask

    task automatic test_single();
        bit ok;
        clear_logs();
        fixed_lat = 6;
        op_a[0] = 8'hFD; op_b[0] = 8'h05;
        @(posedge clk); #3 pending = 4'b0001;
        wait_rsps(1, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_rsp: got %0d responses want 1", r_cyc.size()); end
        if (ok) begin
            checks++; if (g_vec[0] !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b want 0001", g_vec[0]); end
            checks++; if (s_cyc[0] !== g_cyc[0] + 1) begin errors++; $display("FAIL single_start_cyc: got %0d want %0d", s_cyc[0], g_cyc[0] + 1); end
            checks++; if (s_a[0] !== 8'hFD || s_b[0] !== 8'h05) begin errors++; $display("FAIL single_ops: got %h/%h want fd/05", s_a[0], s_b[0]); end
            checks++; if (r_cyc[0] !== s_cyc[0] + 7) begin errors++; $display("FAIL single_rsp_cyc: got %0d want %0d", r_cyc[0], s_cyc[0] + 7); end
            checks++; if (r_vec[0] !== 4'b0001) begin errors++; $display("FAIL single_rsp_valid: got %b want 0001", r_vec[0]); end
            checks++; if (r_data[0] !== 16'hFFF1) begin errors++; $display("FAIL single_data: got %h want fff1", r_data[0]); end
            checks++; if (r_err[0] !== 1'b0) begin errors++; $display("FAIL single_err: got %b want 0", r_err[0]); end
        end
        model_last = 0;
    endtask

    task automatic test_fairness();
        bit ok;
        int w;
        pulse_reset();
        clear_logs();
        fixed_lat = 0;
        for (int i = 0; i < int'(N); i++) begin op_a[i] = W'($urandom); op_b[i] = W'($urandom); end
        sticky = 1'b1;
        @(posedge clk); #3 pending = 4'b1111;
        wait_rsps(5, 200, ok);
        sticky = 1'b0;
        pending = '0;
        repeat (20) @(posedge clk);
        checks++; if (!ok) begin errors++; $display("FAIL fair_rsp: got %0d responses want 5", r_cyc.size()); end
        if (ok) begin
            for (int k = 0; k < 5; k++) begin
                w = k % int'(N);
                checks++; if (g_vec[k] !== N'(1) << w) begin errors++; $display("FAIL fair_order[%0d]: got %b want %b", k, g_vec[k], N'(1) << w); end
                checks++; if (r_vec[k] !== g_vec[k]) begin errors++; $display("FAIL fair_owner[%0d]: got %b want %b", k, r_vec[k], g_vec[k]); end
                checks++; if (r_data[k] !== prod(op_a[w], op_b[w]) || r_err[k] !== 1'b0) begin errors++; $display("FAIL fair_data[%0d]: got %h err %b want %h err 0", k, r_data[k], r_err[k], prod(op_a[w], op_b[w])); end
                if (k > 0) begin
                    checks++; if (g_cyc[k] - g_cyc[k-1] !== 3 + lat_q[k-1]) begin errors++; $display("FAIL fair_spacing[%0d]: got %0d want %0d", k, g_cyc[k] - g_cyc[k-1], 3 + lat_q[k-1]); end
                end
            end
            model_last = rr_pick(g_req[g_req.size()-1], 0);
            model_last = $clog2(g_vec[g_vec.size()-1]);
        end
    endtask

    task automatic test_random();
        bit ok;
        int n, w;
        for (int round = 0; round < 8; round++) begin
            clear_logs();
            fixed_lat = 0;
            for (int i = 0; i < int'(N); i++) begin op_a[i] = W'($urandom); op_b[i] = W'($urandom); end
            @(posedge clk); #3 pending = N'($urandom_range(1, 15));
            n = $countones(pending);
            wait_rsps(n, n * 20 + 20, ok);
            checks++; if (!ok) begin errors++; $display("FAIL rand_rsp[%0d]: got %0d responses want %0d", round, r_cyc.size(), n); end
            if (ok) begin
                for (int k = 0; k < n; k++) begin
                    w = rr_pick(g_req[k], model_last);
                    checks++; if (g_vec[k] !== N'(1) << w) begin errors++; $display("FAIL rand_gnt[%0d.%0d]: got %b want %b", round, k, g_vec[k], N'(1) << w); end
                    checks++; if (r_vec[k] !== N'(1) << w) begin errors++; $display("FAIL rand_owner[%0d.%0d]: got %b want %b", round, k, r_vec[k], N'(1) << w); end
                    checks++; if (r_data[k] !== prod(op_a[w], op_b[w]) || r_err[k] !== 1'b0) begin errors++; $display("FAIL rand_data[%0d.%0d]: got %h err %b want %h err 0", round, k, r_data[k], r_err[k], prod(op_a[w], op_b[w])); end
                    checks++; if (r_cyc[k] - s_cyc[k] !== exp_delay(lat_q[k])) begin errors++; $display("FAIL rand_latency[%0d.%0d]: got %0d want %0d", round, k, r_cyc[k] - s_cyc[k], exp_delay(lat_q[k])); end
                    model_last = w;
                end
            end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int w;
        clear_logs();
        fixed_lat = -1;
        op_a[2] = W'($urandom); op_b[2] = W'($urandom);
        @(posedge clk); #3 pending = 4'b0100;
        wait_rsps(1, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL to_rsp: got %0d responses want 1", r_cyc.size()); end
        if (ok) begin
            checks++; if (r_cyc[0] - s_cyc[0] !== int'(TO)) begin errors++; $display("FAIL to_cyc: got %0d want %0d", r_cyc[0] - s_cyc[0], TO); end
            checks++; if (r_err[0] !== 1'b1 || r_data[0] !== '0) begin errors++; $display("FAIL to_err: got err %b data %h want err 1 data 0", r_err[0], r_data[0]); end
            checks++; if (r_vec[0] !== 4'b0100) begin errors++; $display("FAIL to_owner: got %b want 0100", r_vec[0]); end
        end
        model_last = 2;
        @(negedge clk);
        checks++; if (bus.rsp_err !== 1'b1 || bus.rsp_data !== '0) begin errors++; $display("FAIL to_hold: got err %b data %h want err 1 data 0", bus.rsp_err, bus.rsp_data); end
        clear_logs();
        fixed_lat = 2;
        op_a[1] = W'($urandom); op_b[1] = W'($urandom);
        @(posedge clk); #3 pending = 4'b0010;
        wait_rsps(1, 40, ok);
        w = rr_pick(4'b0010, model_last);
        checks++; if (!ok) begin errors++; $display("FAIL to_next_rsp: got %0d responses want 1", r_cyc.size()); end
        if (ok) begin
            checks++; if (r_vec[0] !== N'(1) << w) begin errors++; $display("FAIL to_next_owner: got %b want %b", r_vec[0], N'(1) << w); end
            checks++; if (r_data[0] !== prod(op_a[1], op_b[1]) || r_err[0] !== 1'b0) begin errors++; $display("FAIL to_next_data: got %h err %b want %h err 0", r_data[0], r_err[0], prod(op_a[1], op_b[1])); end
            checks++; if (r_cyc[0] - s_cyc[0] !== 3) begin errors++; $display("FAIL to_next_cyc: got %0d want 3", r_cyc[0] - s_cyc[0]); end
        end
        model_last = w;
        repeat (3) @(negedge clk);
        checks++; if (bus.rsp_data !== prod(op_a[1], op_b[1])) begin errors++; $display("FAIL data_hold: got %h want %h", bus.rsp_data, prod(op_a[1], op_b[1])); end
    endtask

    task automatic test_collision();
        bit ok;
        clear_logs();
        inject_launch = 1'b1;
        fixed_lat = int'(TO) - 1;
        op_a[3] = W'($urandom); op_b[3] = W'($urandom);
        @(posedge clk); #3 pending = 4'b1000;
        wait_rsps(1, 100, ok);
        inject_launch = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL coll_rsp: got %0d responses want 1", r_cyc.size()); end
        if (ok) begin
            checks++; if (r_cyc[0] - s_cyc[0] !== int'(TO)) begin errors++; $display("FAIL coll_cyc: got %0d want %0d", r_cyc[0] - s_cyc[0], TO); end
            checks++; if (r_err[0] !== 1'b0 || r_data[0] !== prod(op_a[3], op_b[3])) begin errors++; $display("FAIL coll_data: got %h err %b want %h err 0", r_data[0], r_err[0], prod(op_a[3], op_b[3])); end
        end
        model_last = 3;
        clear_logs();
        fixed_lat = int'(TO);
        @(posedge clk); #3 pending = 4'b0001;
        wait_rsps(1, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL late_rsp: got %0d responses want 1", r_cyc.size()); end
        if (ok) begin
            checks++; if (r_err[0] !== 1'b1 || r_data[0] !== '0 || r_cyc[0] - s_cyc[0] !== int'(TO)) begin errors++; $display("FAIL late_err: got err %b data %h delay %0d want err 1 data 0 delay %0d", r_err[0], r_data[0], r_cyc[0] - s_cyc[0], TO); end
        end
        model_last = 0;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_reset_mid();
        bit ok;
        int t;
        clear_logs();
        fixed_lat = -1;
        op_a[2] = W'($urandom) | 8'h01; op_b[2] = W'($urandom) | 8'h01;
        @(posedge clk); #3 pending = 4'b0100;
        t = 0;
        while (s_cyc.size() == 0 && t < 20) begin @(negedge clk); #1; t++; end
        checks++; if (s_cyc.size() == 0) begin errors++; $display("FAIL rmid_launch: got no launch want 1"); end
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus.gnt !== '0 || bus.rsp_valid !== '0 || bus.mul_start !== 1'b0) begin errors++; $display("FAIL rmid_pulses: got gnt %b rv %b ms %b want 0", bus.gnt, bus.rsp_valid, bus.mul_start); end
        checks++; if (bus.rsp_err !== 1'b0 || bus.rsp_data !== '0 || bus.mul_a !== '0 || bus.mul_b !== '0) begin errors++; $display("FAIL rmid_regs: got err %b data %h a %h b %h want 0", bus.rsp_err, bus.rsp_data, bus.mul_a, bus.mul_b); end
        @(posedge clk); #3 rst = 1'b0;
        model_last = N - 1;
        repeat (80) @(posedge clk);
        checks++; if (r_cyc.size() != 0) begin errors++; $display("FAIL rmid_no_rsp: got %0d responses want 0", r_cyc.size()); end
        clear_logs();
        fixed_lat = 3;
        for (int i = 0; i < int'(N); i++) begin op_a[i] = W'($urandom); op_b[i] = W'($urandom); end
        @(posedge clk); #3 pending = 4'b1111;
        wait_rsps(4, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rmid_rsp: got %0d responses want 4", r_cyc.size()); end
        if (ok) begin
            checks++; if (g_vec[0] !== 4'b0001) begin errors++; $display("FAIL rmid_first_gnt: got %b want 0001", g_vec[0]); end
            checks++; if (r_data[3] !== prod(op_a[3], op_b[3])) begin errors++; $display("FAIL rmid_data: got %h want %h", r_data[3], prod(op_a[3], op_b[3])); end
        end
        checks++; if (overlap_cnt != 0) begin errors++; $display("FAIL pulse_overlap: got %0d cycles want 0", overlap_cnt); end
    endtask

    initial begin
        rst = 1'b1;
        bus.req = '0;
        bus.a_in = '0;
        bus.b_in = '0;
        bus.mul_done = 1'b0;
        bus.mul_p = '0;
        for (int i = 0; i < int'(N); i++) begin op_a[i] = '0; op_b[i] = '0; end
        test_reset();
        test_single();
        test_fairness();
        test_random();
        test_timeout();
        test_collision();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_scheduler.md
MUL_SCHEDULER -- requirements
Module: mul_scheduler

Interface
REQ-001 Parameters SHALL be: N_REQ, 4, number of requesters; WIDTH, 8, operand width; TIMEOUT, 64, max cycles waited for mul_done.
REQ-002 clk  input  1  the only clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req  input  N_REQ  per-requester request, held high until the matching gnt bit is seen.
REQ-005 a_in, b_in  input  N_REQ*WIDTH each  packed per-requester operands; slice i valid while req[i]=1.
REQ-006 gnt  output  N_REQ  one-hot, one-cycle pulse; operands of the granted requester are captured in that cycle.
REQ-007 rsp_valid  output  N_REQ  one-hot, one-cycle pulse to the requester owning the current operation.
REQ-008 rsp_data  output  2*WIDTH  product, valid when any rsp_valid bit is 1; shared by all requesters.
REQ-009 rsp_err  output  1  timeout flag, qualified by rsp_valid.
REQ-010 mul_start  output  1  one-cycle launch pulse to the Booth multiplier datapath/CU.
REQ-011 mul_a, mul_b  output  WIDTH each  registered operands, stable from the LAUNCH cycle until the operation ends.
REQ-012 mul_done  input  1  multiplier completion pulse.
REQ-013 mul_p  input  2*WIDTH  signed product, valid with mul_done.

Function
REQ-014 FSM SHALL have exactly four states: IDLE, LAUNCH, WAIT, RESP.
REQ-015 IDLE: if req!=0, assert gnt for the round-robin winner, latch its a/b slices and index, go to LAUNCH; else stay.
REQ-016 Round-robin: search starts at last_gnt+1 modulo N_REQ; last_gnt updates on the gnt cycle.
REQ-017 LAUNCH: mul_start=1 for exactly this cycle, clear the watchdog counter, go to WAIT; mul_done here SHALL be ignored.
REQ-018 WAIT: mul_done=1 -> latch mul_p into rsp_data, rsp_err=0, go to RESP.
REQ-019 WAIT: watchdog increments each cycle; when it reaches TIMEOUT-1 without mul_done -> rsp_data=0, rsp_err=1, go to RESP.
REQ-020 mul_done and watchdog expiry in the same cycle: mul_done wins (rsp_err=0).
REQ-021 RESP: rsp_valid[owner]=1 for one cycle, then go to IDLE; a new grant is possible in the next cycle.
REQ-022 Throughput: minimum gnt-to-gnt spacing SHALL be 4 cycles when the multiplier responds in 1 WAIT cycle.
REQ-023 req changes in LAUNCH/WAIT/RESP SHALL have no effect; gnt, rsp_valid, and mul_start SHALL never be high in the same cycle.
REQ-024 mul_done outside WAIT SHALL be ignored; rsp_data/rsp_err SHALL hold their last values outside RESP.
REQ-025 Products SHALL pass through unmodified as 2*WIDTH two's-complement values; no truncation or sign handling.

Reset
REQ-026 rst=1 at a clock edge: state=IDLE; gnt, rsp_valid, mul_start, rsp_err=0; rsp_data, mul_a, mul_b=0; watchdog=0; last_gnt=N_REQ-1 (requester 0 wins first).
REQ-027 rst asserted mid-operation SHALL abort it; no rsp_valid for the aborted request, which must re-request.

Structure
REQ-028 A shared package SHALL hold the state enum (IDLE, LAUNCH, WAIT, RESP) and default values for WIDTH, N_REQ, and TIMEOUT.
REQ-029 Round-robin selection SHALL be one sub-module, rr_arbiter (inputs: req, last_gnt; output: one-hot grant), purely combinational.

Verification
REQ-030 Single request: req=4'b0001, a0=8'hFD, b0=8'h05, multiplier done after 6 cycles -> gnt[0] pulse, mul_start one cycle later, rsp_valid[0] with rsp_data=16'hFFF1, rsp_err=0.
REQ-031 Fairness: req=4'b1111 held continuously -> grants in the order 0,1,2,3,0 with spacing of 3 plus the multiplier latency.
REQ-032 Timeout: mul_done never asserted, TIMEOUT=64 -> rsp_valid[owner] with rsp_err=1 and rsp_data=0 exactly 64 cycles after mul_start; next request served normally.
REQ-033 Collision: mul_done pulse in the LAUNCH cycle is ignored; in the final WAIT cycle, simultaneous with expiry, it yields rsp_err=0 with the product.
REQ-034 Reset mid-WAIT: rst=1 for 1 cycle -> all outputs 0, state IDLE, no rsp_valid; the next grant goes to requester 0 if requested.
